// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: shared definitions for the instruction sequencer.
//   seq_state_e     - FSM state encoding. The codes are shown on the LCD.
//   StateW          - width of the exported state code.
//   DefaultStepDiv  - default IDLE cycles per instruction in run mode.
package exec_sequencer_pkg;

    localparam int unsigned StateW         = 3;
    localparam int unsigned DefaultStepDiv = 50_000_000;

    typedef enum logic [StateW-1:0] {
        StIdle   = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StCommit = 3'd3,
        StHalt   = 3'd4,
        StLoad   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: signal bundle between the sequencer and the MIPS top level.
//   Datapath/board -> sequencer: SEQ_run, SEQ_step, SEQ_load, SEQ_pc_val, SEQ_pc_next,
//                                SEQ_eh_flag, SEQ_reg_write_req, SEQ_mem_write_req
//   Sequencer -> datapath/board: SEQ_pc, SEQ_reg_we, SEQ_dmem_we, SEQ_state,
//                                SEQ_halted, SEQ_epc, SEQ_instr_count
// modport master: the datapath/board side. modport slave: the sequencer.
interface exec_sequencer_if #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
);
    import exec_sequencer_pkg::*;

    logic              SEQ_run;
    logic              SEQ_step;
    logic              SEQ_load;
    logic [PC_W-1:0]   SEQ_pc_val;
    logic [PC_W-1:0]   SEQ_pc_next;
    logic              SEQ_eh_flag;
    logic              SEQ_reg_write_req;
    logic              SEQ_mem_write_req;
    logic [PC_W-1:0]   SEQ_pc;
    logic              SEQ_reg_we;
    logic              SEQ_dmem_we;
    logic [StateW-1:0] SEQ_state;
    logic              SEQ_halted;
    logic [PC_W-1:0]   SEQ_epc;
    logic [CNT_W-1:0]  SEQ_instr_count;

    modport master (
        output SEQ_run, SEQ_step, SEQ_load, SEQ_pc_val, SEQ_pc_next, SEQ_eh_flag,
               SEQ_reg_write_req, SEQ_mem_write_req,
        input  SEQ_pc, SEQ_reg_we, SEQ_dmem_we, SEQ_state, SEQ_halted, SEQ_epc,
               SEQ_instr_count
    );

    modport slave (
        input  SEQ_run, SEQ_step, SEQ_load, SEQ_pc_val, SEQ_pc_next, SEQ_eh_flag,
               SEQ_reg_write_req, SEQ_mem_write_req,
        output SEQ_pc, SEQ_reg_we, SEQ_dmem_we, SEQ_state, SEQ_halted, SEQ_epc,
               SEQ_instr_count
    );

endinterface

// File: rtl/exec_sequencer_step_sync.sv
// exec_sequencer_step_sync: pushbutton conditioner for single-step mode.
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   step_raw   in  raw pushbutton, asynchronous to clk
//   step_pulse out one-cycle pulse per button press (rising edge)
// A raw rise sampled at edge k appears as step_pulse in the cycle after edge k+1.
module exec_sequencer_step_sync (
    input  logic clk,
    input  logic rst,
    input  logic step_raw,
    output logic step_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= step_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Held button stays high in sync2_q and prev_q, so only the first cycle pulses.
    assign step_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer for the single-cycle MIPS datapath.
// Owns the PC, gates the register-file and DMEM write strobes, and halts on exceptions.
//   SYS_clk  in  system clock, rising edge
//   SYS_rst  in  synchronous active-high reset
//   seq      slave side of exec_sequencer_if (run/step/load controls, next PC,
//            exception flag, write requests in; PC, gated strobes, state, halt,
//            EPC and retired-instruction count out)
// Sequence per instruction: IDLE -> DECODE -> EXEC -> COMMIT -> IDLE.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned STEP_DIV = DefaultStepDiv,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            SYS_clk,
    input  logic            SYS_rst,
    exec_sequencer_if.slave seq
);

    localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

    seq_state_e       state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic step_pulse;
    logic run_trig;
    logic step_trig;
    logic trigger;
    logic reg_we;
    logic dmem_we;

    exec_sequencer_step_sync u_step_sync (
        .clk        (SYS_clk),
        .rst        (SYS_rst),
        .step_raw   (seq.SEQ_step),
        .step_pulse (step_pulse)
    );

    // Triggers are only acted on in IDLE. Step pulses in run mode are dropped.
    assign run_trig  = seq.SEQ_run && (div_q == DivLast);
    assign step_trig = !seq.SEQ_run && step_pulse;
    assign trigger   = run_trig || step_trig;

    // State register
    always_ff @(posedge SYS_clk) begin
        if (SYS_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle: begin
                if (seq.SEQ_load) begin
                    state_d = StLoad;
                end else if (trigger) begin
                    state_d = StDecode;
                end else begin
                    state_d = StIdle;
                end
            end
            StDecode: state_d = seq.SEQ_eh_flag ? StHalt : StExec;
            StExec:   state_d = StCommit;
            StCommit: state_d = StIdle;
            StHalt:   state_d = seq.SEQ_load ? StLoad : StHalt;
            StLoad:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic: strobes depend on state only, so a reset edge kills them at once.
    always_comb begin
        reg_we  = 1'b0;
        dmem_we = 1'b0;
        if (state_q == StExec) begin
            reg_we  = seq.SEQ_reg_write_req;
            dmem_we = seq.SEQ_mem_write_req;
        end
    end

    // Divider: counts IDLE cycles in run mode, cleared whenever it is not counting.
    always_comb begin
        div_d = '0;
        if (state_q == StIdle && seq.SEQ_run && !trigger && !seq.SEQ_load) begin
            div_d = div_q + DivW'(1);
        end
    end

    // PC, EPC, halt flag and retired-instruction counter
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            StDecode: begin
                if (seq.SEQ_eh_flag) begin
                    epc_d    = pc_q;
                    halted_d = 1'b1;
                end
            end
            StCommit: begin
                pc_d    = seq.SEQ_pc_next;
                count_d = count_q + CNT_W'(1);
            end
            StLoad: begin
                pc_d     = seq.SEQ_pc_val;
                halted_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_rst) begin
            div_q    <= '0;
            pc_q     <= '0;
            epc_q    <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            div_q    <= div_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign seq.SEQ_pc          = pc_q;
    assign seq.SEQ_reg_we      = reg_we;
    assign seq.SEQ_dmem_we     = dmem_we;
    assign seq.SEQ_state       = state_q;
    assign seq.SEQ_halted      = halted_q;
    assign seq.SEQ_epc         = epc_q;
    assign seq.SEQ_instr_count = count_q;

endmodule
